// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM responder: word-organised memory, optional wait states, two-cycle ERROR response.
module ahb3lite_sram_slave #(
    parameter int unsigned HADDR_SIZE  = 16,
    parameter int unsigned HDATA_SIZE  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned BYTES     = HDATA_SIZE / 8;
    localparam int unsigned ADDR_LSB  = $clog2(BYTES);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam logic        HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    logic [2:0]          state, state_next;
    logic [3:0]          cnt, cnt_next;
    logic [IDX_W-1:0]    idx_q;
    logic [ADDR_LSB-1:0] lane_q;
    logic [2:0]          size_q;
    logic                write_q;

    logic                accept;
    logic                req_err;
    logic [7:0]          size_bytes;
    logic [7:0]          size_mask;
    logic [15:0]         be_wide;
    logic [BYTES-1:0]    be;
    logic                unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // Address-phase qualification and error classification of the incoming request.
    assign accept     = HSEL & HREADY & HTRANS[1];
    assign size_bytes = 8'd1 << HSIZE;
    assign req_err    = ((HADDR >> ADDR_LSB) >= HADDR_SIZE'(MEM_DEPTH))
                      | (HSIZE > 3'(ADDR_LSB))
                      | (|(HADDR[ADDR_LSB-1:0] & ADDR_LSB'(size_bytes - 8'd1)));

    // State, wait counter and latched address-phase controls.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                idx_q   <= IDX_W'(HADDR >> ADDR_LSB);
                lane_q  <= HADDR[ADDR_LSB-1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
        end
    end

    // Next-state logic; IDLE, DATA and ERR2 all sit in an address phase and may accept.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_next = ST_ERR1;
                    end else if (HAS_WAIT) begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_DATA;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    // Byte-lane enables from the latched size and low address bits.
    always_comb begin
        case (size_q)
            3'd0:    size_mask = 8'h01;
            3'd1:    size_mask = 8'h03;
            3'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        be_wide = 16'(size_mask) << lane_q;
        be      = be_wide[BYTES-1:0];
    end

    // Memory write on the edge that ends an OKAY write data phase; contents are never reset.
    always_ff @(posedge HCLK) begin
        if (state == ST_DATA && write_q) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (be[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Response signals decoded directly from the state register.
    assign HREADYOUT = (state != ST_WAIT) && (state != ST_ERR1);
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    assign HRDATA    = (state == ST_DATA) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: one zero-wait and one three-wait instance on a shared bus with separate selects.
`timescale 1ns/1ps
module tb_ahb3lite_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel0, sel1;
    logic [15:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hrdata0, hrdata1;
    logic        hreadyout0, hreadyout1;
    logic        hresp0, hresp1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata0),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(htrans),
        .HMASTLOCK(1'b0), .HREADY(hreadyout0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
    );

    ahb3lite_sram_slave #(.HADDR_SIZE(16), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(sel1), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata1),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(htrans),
        .HMASTLOCK(1'b0), .HREADY(hreadyout1), .HREADYOUT(hreadyout1), .HRESP(hresp1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One single transfer with an idle cycle before it; returns in the final data-phase cycle.
    task automatic xfer(input int d, input logic wr, input logic [15:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output int waits,
                        output logic rlow, output logic rfin);
        logic rdy;
        @(negedge clk);
        sel0 = (d == 0); sel1 = (d == 1);
        haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10;
        @(posedge clk);
        @(negedge clk);
        sel0 = 1'b0; sel1 = 1'b0; htrans = 2'b00; hwdata = wd;
        waits = 0; rlow = 1'b0;
        rdy = (d == 0) ? hreadyout0 : hreadyout1;
        while (!rdy && waits < 50) begin
            rlow |= (d == 0) ? hresp0 : hresp1;
            waits++;
            @(negedge clk);
            rdy = (d == 0) ? hreadyout0 : hreadyout1;
        end
        if (!rdy) begin
            n_checks++;
            $display("FAIL timeout: HREADYOUT stuck low on dut%0d, expected high within 50 cycles", d);
        end
        rd   = (d == 0) ? hrdata0 : hrdata1;
        rfin = (d == 0) ? hresp0 : hresp1;
    endtask

    initial begin
        logic [31:0] rd;
        int          w;
        logic        rl, rf;

        rst = 1'b1; sel0 = 1'b0; sel1 = 1'b0; haddr = '0; hwdata = '0;
        hwrite = 1'b0; hsize = 3'd2; htrans = 2'b00;
        #12;
        check("rst_ready0", 32'(hreadyout0), 32'd1);
        check("rst_resp0",  32'(hresp0),     32'd0);
        check("rst_rdata0", hrdata0,         32'd0);
        check("rst_ready1", 32'(hreadyout1), 32'd1);
        @(negedge clk); rst = 1'b0;

        // Zero-wait word write and read-back.
        xfer(0, 1'b1, 16'h0010, 3'd2, 32'hDEADBEEF, rd, w, rl, rf);
        check("w0_waits", 32'(w), 32'd0);
        check("w0_resp",  32'(rf), 32'd0);
        xfer(0, 1'b0, 16'h0010, 3'd2, 32'h0, rd, w, rl, rf);
        check("r0_waits", 32'(w), 32'd0);
        check("r0_data",  rd, 32'hDEADBEEF);

        // Byte lane 3, then halfword lanes 0-1.
        xfer(0, 1'b1, 16'h0010, 3'd2, 32'h00000000, rd, w, rl, rf);
        xfer(0, 1'b1, 16'h0013, 3'd0, 32'hA5000000, rd, w, rl, rf);
        xfer(0, 1'b0, 16'h0010, 3'd2, 32'h0, rd, w, rl, rf);
        check("byte_data", rd, 32'hA5000000);
        xfer(0, 1'b1, 16'h0010, 3'd1, 32'hFFFF1234, rd, w, rl, rf);
        xfer(0, 1'b0, 16'h0010, 3'd2, 32'h0, rd, w, rl, rf);
        check("half_data", rd, 32'hA5001234);

        // Out-of-range read: one low cycle with ERROR, then high with ERROR.
        xfer(0, 1'b0, 16'h0400, 3'd2, 32'h0, rd, w, rl, rf);
        check("oor_waits", 32'(w),  32'd1);
        check("oor_resp1", 32'(rl), 32'd1);
        check("oor_resp2", 32'(rf), 32'd1);

        // Unaligned word write errors and leaves memory alone.
        xfer(0, 1'b1, 16'h0012, 3'd2, 32'hFFFFFFFF, rd, w, rl, rf);
        check("unal_waits", 32'(w),  32'd1);
        check("unal_resp",  32'(rf), 32'd1);
        xfer(0, 1'b0, 16'h0010, 3'd2, 32'h0, rd, w, rl, rf);
        check("unal_mem",  rd, 32'hA5001234);

        // Oversized transfer errors.
        xfer(0, 1'b0, 16'h0010, 3'd3, 32'h0, rd, w, rl, rf);
        check("size_resp", 32'(rf), 32'd1);
        check("size_rlow", 32'(rl), 32'd1);

        // Last valid word.
        xfer(0, 1'b1, 16'h03FC, 3'd2, 32'hCAFEF00D, rd, w, rl, rf);
        check("top_wresp", 32'(rf), 32'd0);
        xfer(0, 1'b0, 16'h03FC, 3'd2, 32'h0, rd, w, rl, rf);
        check("top_data",  rd, 32'hCAFEF00D);

        // Pipelined write then read of the same word.
        @(negedge clk);
        sel0 = 1'b1; haddr = 16'h0020; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(negedge clk);
        hwdata = 32'h5A5A1234; hwrite = 1'b0;
        check("b2b_wready", 32'(hreadyout0), 32'd1);
        @(negedge clk);
        sel0 = 1'b0; htrans = 2'b00;
        check("b2b_ready", 32'(hreadyout0), 32'd1);
        check("b2b_data",  hrdata0, 32'h5A5A1234);

        // Three wait states on the slow instance.
        xfer(1, 1'b1, 16'h0004, 3'd2, 32'h12345678, rd, w, rl, rf);
        check("ws_wwaits", 32'(w), 32'd3);
        xfer(1, 1'b0, 16'h0004, 3'd2, 32'h0, rd, w, rl, rf);
        check("ws_rwaits", 32'(w),  32'd3);
        check("ws_rlow",   32'(rl), 32'd0);
        check("ws_rfin",   32'(rf), 32'd0);
        check("ws_data",   rd, 32'h12345678);

        // Reset pulse in the middle of a waited write.
        xfer(1, 1'b1, 16'h0030, 3'd2, 32'h0BADF00D, rd, w, rl, rf);
        @(negedge clk);
        sel1 = 1'b1; haddr = 16'h0030; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(negedge clk);
        sel1 = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        check("rstw_inwait", 32'(hreadyout1), 32'd0);
        rst = 1'b1;
        #1;
        check("rstw_ready", 32'(hreadyout1), 32'd1);
        check("rstw_resp",  32'(hresp1),     32'd0);
        check("rstw_rdata", hrdata1,         32'd0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        xfer(1, 1'b0, 16'h0030, 3'd2, 32'h0, rd, w, rl, rf);
        check("rstw_mem", rd, 32'h0BADF00D);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
